// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with its IF/ID pipeline register.
//
// Purpose:
//   Holds the fetch PC, drives the instruction ROM, and registers the
//   returned instruction into the IF/ID register. After reset the stage
//   spends one cycle in IDLE (ROM disabled) and then fetches continuously.
//
// Ports:
//   clk            single clock, rising-edge active
//   rst            asynchronous reset, active-low
//   stall[5:0]     bit0 = hold PC, bit1 = hold IF, bit2 = hold ID; 5:3 unused
//   flush          redirect to new_pc; overrides stalls and branches
//   new_pc[31:0]   redirect address used with flush
//   branch_flag    taken branch/jump resolved in ID
//   branch_target  branch/jump destination
//   ce             instruction ROM enable
//   pc[31:0]       instruction ROM address
//   rom_inst[31:0] instruction word returned by the ROM
//   rom_pc[31:0]   address echoed by the ROM with rom_inst
//   id_pc[31:0]    IF/ID registered PC
//   id_inst[31:0]  IF/ID registered instruction (NOP when misaligned)
//   id_adel[0:0]   IF/ID flag: fetch address not word-aligned

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        ce,
  output logic [31:0] pc,
  input  logic [31:0] rom_inst,
  input  logic [31:0] rom_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic        rom_adel;
  logic        id_bubble;

  // Upper stall bits belong to later stages and have no meaning here.
  logic stall_unused;
  assign stall_unused = ^stall[5:3];

  // State register: reset always returns the stage to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: IDLE lasts exactly one edge; FETCH is left only via reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = FETCH;
      FETCH:   state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: the ROM is enabled only while fetching.
  always_comb begin
    ce = 1'b0;
    if (state == FETCH) begin
      ce = 1'b1;
    end
  end

  // Next PC. Flush beats the PC hold; a branch seen during a PC hold is
  // dropped because ID re-issues it once the stall clears.
  always_comb begin
    pc_next = pc;
    if (state == IDLE) begin
      pc_next = RESET_PC;
    end else if (flush) begin
      pc_next = new_pc;
    end else if (!stall[0]) begin
      if (branch_flag) begin
        pc_next = branch_target;
      end else begin
        pc_next = pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // A bubble is inserted when the fetched word is invalid (flush, not yet
  // fetching) or when IF stalls but ID moves on, so ID does not repeat it.
  assign rom_adel  = (rom_pc[1:0] != 2'b00);
  assign id_bubble = flush | (stall[1] & ~stall[2]) | ~ce;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc   <= 32'h0;
      id_inst <= 32'h0;
      id_adel <= 1'b0;
    end else if (id_bubble) begin
      id_pc   <= 32'h0;
      id_inst <= 32'h0;
      id_adel <= 1'b0;
    end else if (!stall[1]) begin
      id_pc   <= rom_pc;
      id_inst <= rom_adel ? 32'h0 : rom_inst;
      id_adel <= rom_adel;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// Purpose:
//   Directed vector table, hand-written reset/wrap sequences, and a
//   randomized run against a behavioural model of the fetch rules.
//
// Ports: none (top-level bench).

module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ce;
  logic [31:0] pc;
  logic [31:0] rom_inst;
  logic [31:0] rom_pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  logic        ce2;
  logic [31:0] pc2;
  logic [31:0] rom_inst2;
  logic [31:0] rom_pc2;
  logic [31:0] id_pc2;
  logic [31:0] id_inst2;
  logic        id_adel2;

  int n_compared;
  int n_mismatched;

  // ROM contents: three known words at the bottom, a recognisable
  // address-derived pattern everywhere else.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  assign rom_inst  = rom_word(pc);
  assign rom_pc    = pc;
  assign rom_inst2 = rom_word(pc2);
  assign rom_pc2   = pc2;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .ce(ce), .pc(pc), .rom_inst(rom_inst), .rom_pc(rom_pc),
    .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel)
  );

  // Second copy with a non-zero reset vector, sharing all control inputs.
  fetch_unit #(.RESET_PC(32'h0000_1000)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .ce(ce2), .pc(pc2), .rom_inst(rom_inst2), .rom_pc(rom_pc2),
    .id_pc(id_pc2), .id_inst(id_inst2), .id_adel(id_adel2)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        exp_ce;
    logic [31:0] exp_pc;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_id_inst;
    logic        exp_id_adel;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [5:0] s, input logic f, input logic [31:0] np,
                              input logic bf, input logic [31:0] bt, input logic [31:0] epc,
                              input logic [31:0] eip, input logic [31:0] eii, input logic ea);
    vec_t v;
    v.stall = s; v.flush = f; v.new_pc = np; v.branch_flag = bf; v.branch_target = bt;
    v.exp_ce = 1'b1; v.exp_pc = epc; v.exp_id_pc = eip; v.exp_id_inst = eii; v.exp_id_adel = ea;
    return v;
  endfunction

  // Compare one observed value against its expectation and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs and step past the next rising edge.
  task automatic applyStimulus(input logic [5:0] s, input logic f, input logic [31:0] np,
                               input logic bf, input logic [31:0] bt);
    stall = s; flush = f; new_pc = np; branch_flag = bf; branch_target = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic ece, input logic [31:0] epc,
                          input logic [31:0] eip, input logic [31:0] eii, input logic ea);
    checkOutput({tag, ".ce"}, {31'h0, ce}, {31'h0, ece});
    checkOutput({tag, ".pc"}, pc, epc);
    checkOutput({tag, ".id_pc"}, id_pc, eip);
    checkOutput({tag, ".id_inst"}, id_inst, eii);
    checkOutput({tag, ".id_adel"}, {31'h0, id_adel}, {31'h0, ea});
  endtask

  // Behavioural model of the fetch rules, used for the randomized run.
  logic        m_fetching;
  logic [31:0] m_pc;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_inst;
  logic        m_id_adel;

  task automatic model_reset();
    m_fetching = 1'b0; m_pc = 32'h0;
    m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_adel = 1'b0;
  endtask

  // One clock edge of the model, using the inputs held during the cycle.
  task automatic model_step();
    if (rst === 1'b0) begin
      model_reset();
      return;
    end
    if (flush || (stall[1] && !stall[2]) || !m_fetching) begin
      m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_adel = 1'b0;
    end else if (!stall[1]) begin
      m_id_pc   = m_pc;
      m_id_adel = (m_pc % 4) != 0;
      m_id_inst = m_id_adel ? 32'h0 : rom_word(m_pc);
    end
    if (!m_fetching) begin
      m_fetching = 1'b1;
    end else if (flush) begin
      m_pc = new_pc;
    end else if (stall[0]) begin
      m_pc = m_pc;
    end else if (branch_flag) begin
      m_pc = branch_target;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Main test sequence: reset, vector table, hand sequences, random run.
  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b0; stall = 6'h0; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;

    vecs[0]  = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h0,   32'h0,   32'h0,           0);
    vecs[1]  = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h4,   32'h0,   32'h11,          0);
    vecs[2]  = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h8,   32'h4,   32'h22,          0);
    vecs[3]  = mk(6'b000000, 0, 32'h0, 1, 32'h40,  32'h40,  32'h8,   32'h33,          0);
    vecs[4]  = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h44,  32'h40,  rom_word(32'h40), 0);
    vecs[5]  = mk(6'b000000, 0, 32'h0, 1, 32'h10,  32'h10,  32'h44,  rom_word(32'h44), 0);
    vecs[6]  = mk(6'b000011, 0, 32'h0, 0, 32'h0,   32'h10,  32'h0,   32'h0,           0);
    vecs[7]  = mk(6'b000011, 0, 32'h0, 0, 32'h0,   32'h10,  32'h0,   32'h0,           0);
    vecs[8]  = mk(6'b000011, 0, 32'h0, 0, 32'h0,   32'h10,  32'h0,   32'h0,           0);
    vecs[9]  = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h14,  32'h10,  rom_word(32'h10), 0);
    vecs[10] = mk(6'b000111, 1, 32'h180, 0, 32'h0, 32'h180, 32'h0,   32'h0,           0);
    vecs[11] = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h184, 32'h180, rom_word(32'h180), 0);
    vecs[12] = mk(6'b000110, 0, 32'h0, 0, 32'h0,   32'h188, 32'h180, rom_word(32'h180), 0);
    vecs[13] = mk(6'b000001, 0, 32'h0, 1, 32'h300, 32'h188, 32'h188, rom_word(32'h188), 0);
    vecs[14] = mk(6'b000000, 0, 32'h0, 1, 32'h42,  32'h42,  32'h188, rom_word(32'h188), 0);
    vecs[15] = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h46,  32'h42,  32'h0,           1);
    vecs[16] = mk(6'b000000, 1, 32'hFFFF_FFFC, 1, 32'h700, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
    vecs[17] = mk(6'b000000, 0, 32'h0, 0, 32'h0,   32'h0,   32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 0);
    vecs[18] = mk(6'b111000, 0, 32'h0, 0, 32'h0,   32'h4,   32'h0,   32'h11,          0);
    vecs[19] = mk(6'b000100, 0, 32'h0, 0, 32'h0,   32'h8,   32'h4,   32'h22,          0);

    // Reset state, held across a clock edge.
    @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("reset.pc2", pc2, 32'h0000_1000);
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].new_pc, vecs[i].branch_flag, vecs[i].branch_target);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_ce, vecs[i].exp_pc,
               vecs[i].exp_id_pc, vecs[i].exp_id_inst, vecs[i].exp_id_adel);
      if (i == 0) checkOutput("vec0.pc2", pc2, 32'h0000_1000);
      if (i == 1) checkOutput("vec1.pc2", pc2, 32'h0000_1004);
    end

    // Wrap, then asynchronous reset mid-cycle with a flush and branch pending.
    applyStimulus(6'b000000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    applyStimulus(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap.pc", pc, 32'h0);
    applyStimulus(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_next.pc", pc, 32'h4);
    stall = 6'b000011; flush = 1'b1; new_pc = 32'h500; branch_flag = 1'b1; branch_target = 32'h600;
    #2;
    rst = 1'b0;
    #1;
    checkAll("async_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("async_rst.pc2", pc2, 32'h0000_1000);
    @(posedge clk);
    #1;
    checkAll("rst_held", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    applyStimulus(6'b000111, 1'b0, 32'h0, 1'b0, 32'h0);
    checkAll("release_stalled", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("release_stalled.pc2", pc2, 32'h0000_1000);
    applyStimulus(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    checkAll("release_run", 1'b1, 32'h4, 32'h0, 32'h11, 1'b0);

    // Randomized run against the model, starting from a fresh reset.
    rst = 1'b0;
    model_reset();
    applyStimulus(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] np;
      logic [31:0] bt;
      np = $urandom;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) np = 32'hFFFF_FFFC;
      rst = ($urandom_range(0, 39) != 0);
      stall = 6'($urandom);
      if ($urandom_range(0, 1) == 0) stall[2:0] = 3'b000;
      flush = ($urandom_range(0, 7) == 0);
      new_pc = np;
      branch_flag = ($urandom_range(0, 3) == 0);
      branch_target = bt;
      model_step();
      @(posedge clk);
      #1;
      checkAll($sformatf("rand%0d", c), m_fetching, m_pc, m_id_pc, m_id_inst, m_id_adel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
